// File: rtl/dsp_fit_scheduler.sv
// dsp_fit_scheduler: round-robin dispatcher driving NDSP multiply-accumulate lanes for the fitter
// Optional feature macro: DSPSCHED_STALL_EN (adds HOLD, which freezes the whole scheduler)
// Ports:
//   CLOCK      system clock, rising edge
//   RESET      synchronous reset, active-low
//   HOLD       (DSPSCHED_STALL_EN only) freeze counters, busy flags, result line and FSM
//   DV, EV     combination valid / end of event
//   READY      a combination can be accepted this cycle
//   MODECP     per-lane load-first-product control
//   MODE0      per-lane accumulate control
//   COEF_IDX   per-lane 6-bit coefficient index
//   RES_VALID, RES_LANE, RES_EOE   result strobe, its lane and its end-of-event tag
//   EV_DONE    one-cycle pulse when the event has fully drained
//   state_out  FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
module dsp_fit_scheduler #(
    parameter int NDSP    = 4,
    parameter int NCOEF   = 6,
    parameter int DSP_LAT = 3
) (
    input  logic              CLOCK,
    input  logic              RESET,
`ifdef DSPSCHED_STALL_EN
    input  logic              HOLD,
`endif
    input  logic              DV,
    input  logic              EV,
    output logic              READY,
    output logic [NDSP-1:0]   MODECP,
    output logic [NDSP-1:0]   MODE0,
    output logic [NDSP*6-1:0] COEF_IDX,
    output logic              RES_VALID,
    output logic [2:0]        RES_LANE,
    output logic              RES_EOE,
    output logic              EV_DONE,
    output logic [1:0]        state_out
);
    localparam int L  = NCOEF + DSP_LAT;
    localparam int RW = (NDSP > 1) ? $clog2(NDSP) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t              state, nstate;
    logic [RW-1:0]       rr;
    logic [NDSP-1:0]     busy;
    logic [5:0]          cnt [NDSP];
    logic [L-1:0]        lv, le;
    logic [L-1:0][2:0]   ll;
    logic                hold, accept, drained;

`ifdef DSPSCHED_STALL_EN
    assign hold = HOLD;
`else
    assign hold = 1'b0;
`endif

    assign READY   = RESET & ~hold & (state == IDLE || state == RUN) & ~busy[rr];
    assign accept  = DV & READY;
    // The result line is entered at accept and sized so its last stage lines up with the DSP output;
    // the event is drained once nothing remains ahead of that last stage.
    assign drained = ~|busy & ~|lv[L-2:0];

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = accept ? (EV ? DRAIN : RUN) : ((EV && !DV) ? DRAIN : IDLE);
            RUN:     nstate = ((accept && EV) || (EV && !DV)) ? DRAIN : RUN;
            DRAIN:   nstate = drained ? DONE : DRAIN;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state <= IDLE;
            rr    <= '0;
            busy  <= '0;
            for (int l = 0; l < NDSP; l++) cnt[l] <= '0;
            lv    <= '0;
            le    <= '0;
            ll    <= '0;
        end else if (!hold) begin
            state <= nstate;
            for (int l = 0; l < NDSP; l++) begin
                if (busy[l]) begin
                    if (cnt[l] == 6'(NCOEF - 1)) begin
                        busy[l] <= 1'b0;
                        cnt[l]  <= '0;
                    end else begin
                        cnt[l]  <= cnt[l] + 6'd1;
                    end
                end
            end
            if (accept) begin
                busy[rr] <= 1'b1;
                cnt[rr]  <= '0;
                rr       <= (rr == RW'(NDSP - 1)) ? '0 : rr + 1'b1;
            end
            lv <= {lv[L-2:0], accept};
            le <= {le[L-2:0], accept & EV};
            ll <= {ll[L-2:0], 3'(rr)};
        end
    end

    always_comb begin
        MODECP   = '0;
        MODE0    = '0;
        COEF_IDX = '0;
        for (int l = 0; l < NDSP; l++) begin
            MODECP[l]         = busy[l] & (cnt[l] == 6'd0) & ~hold;
            MODE0[l]          = busy[l] & (cnt[l] != 6'd0) & ~hold;
            COEF_IDX[l*6 +: 6] = busy[l] ? cnt[l] : 6'd0;
        end
    end

    assign RES_VALID = lv[L-1] & ~hold;
    assign RES_LANE  = ll[L-1];
    assign RES_EOE   = le[L-1] & RES_VALID;
    assign EV_DONE   = (state == DONE) & ~hold;
    assign state_out = state;
endmodule

// File: tb/tb_dsp_fit_scheduler.sv
// tb_dsp_fit_scheduler: random and directed stimulus against a timestamp-based reference model
module tb_dsp_fit_scheduler;
    localparam int NDSP = 4, NCOEF = 6, DSP_LAT = 3, NCYC = 4000;

    logic              CLOCK = 1'b0, RESET = 1'b0, DV = 1'b0, EV = 1'b0;
    logic              READY, RES_VALID, RES_EOE, EV_DONE;
    logic [NDSP-1:0]   MODECP, MODE0;
    logic [NDSP*6-1:0] COEF_IDX;
    logic [2:0]        RES_LANE;
    logic [1:0]        state_out;

    dsp_fit_scheduler #(.NDSP(NDSP), .NCOEF(NCOEF), .DSP_LAT(DSP_LAT)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
`ifdef DSPSCHED_STALL_EN
        .HOLD(1'b0),
`endif
        .DV(DV), .EV(EV), .READY(READY), .MODECP(MODECP), .MODE0(MODE0),
        .COEF_IDX(COEF_IDX), .RES_VALID(RES_VALID), .RES_LANE(RES_LANE),
        .RES_EOE(RES_EOE), .EV_DONE(EV_DONE), .state_out(state_out)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {int due; int lane; bit eoe;} res_t;

    int   n_chk = 0, n_fail = 0, cyc = 0;
    res_t q[$];
    int   acc_t[NDSP];
    int   rr, ph;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        foreach (acc_t[l]) acc_t[l] = -1000;
        rr = 0;
        ph = 0;
    endtask

    initial begin
        logic [NDSP-1:0]   ecp, em0;
        logic [NDSP*6-1:0] ecoef;
        bit                eready, evalid, drained, acc;
        int                k;
        model_reset();
        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge CLOCK);
            #1;
            if (cyc < 100) begin
                RESET = !(cyc < 3 || cyc == 74);
                DV    = (cyc == 10) || (cyc >= 40 && cyc < 50) || (cyc >= 70 && cyc < 73) || (cyc == 80);
                EV    = (cyc == 30) || (cyc == 42);
            end else begin
                RESET = ($urandom_range(0, 299) != 0);
                DV    = ($urandom_range(0, 3) != 0);
                EV    = ($urandom_range(0, 15) == 0);
            end
            @(negedge CLOCK);
            ecp = '0;
            em0 = '0;
            ecoef = '0;
            for (int l = 0; l < NDSP; l++) begin
                k = cyc - acc_t[l];
                if (k >= 1 && k <= NCOEF) begin
                    if (k == 1) ecp[l] = 1'b1;
                    else        em0[l] = 1'b1;
                    ecoef[l*6 +: 6] = 6'(k - 1);
                end
            end
            eready = RESET && (ph <= 1) && (cyc - acc_t[rr] > NCOEF);
            evalid = (q.size() > 0) && (q[0].due == cyc);
            check("ready", READY, eready);
            check("modecp", MODECP, ecp);
            check("mode0", MODE0, em0);
            check("coef_idx", COEF_IDX, ecoef);
            check("res_valid", RES_VALID, evalid);
            if (evalid) begin
                check("res_lane", RES_LANE, q[0].lane);
                check("res_eoe", RES_EOE, q[0].eoe);
            end
            check("ev_done", EV_DONE, ph == 3);
            check("state", state_out, ph);
            if (!RESET) begin
                model_reset();
            end else begin
                if (evalid) void'(q.pop_front());
                drained = (q.size() == 0);
                for (int l = 0; l < NDSP; l++)
                    if (cyc - acc_t[l] <= NCOEF) drained = 1'b0;
                acc = DV && eready;
                case (ph)
                    0:       ph = acc ? (EV ? 2 : 1) : ((EV && !DV) ? 2 : 0);
                    1:       ph = ((acc && EV) || (EV && !DV)) ? 2 : 1;
                    2:       ph = drained ? 3 : 2;
                    default: ph = 0;
                endcase
                if (acc) begin
                    q.push_back('{due: cyc + NCOEF + DSP_LAT, lane: rr, eoe: EV});
                    acc_t[rr] = cyc;
                    rr = (rr + 1) % NDSP;
                end
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
